alu_cmd_stage: RTL and testbench

Command front-end for the 16-bit combinational ALU (select codes 0-11 legal, 12-15 undefined). It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It drives registered, stable operands and select into the ALU, then captures the ALU result into an output register with a valid/ready handshake. Illegal selects are sanitised, and zero/illegal flags are generated.

---
 rtl/alu_cmd_stage.sv | 212 +++++++++++++++++++++
 tb/tb_alu_cmd_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_stage.sv
// alu_cmd_stage: command front-end for the 16-bit combinational ALU.
// Commands are buffered in a small FIFO, issued to the ALU from a stable
// operand register (S1), and the ALU result is captured into a result
// register that is offered downstream over valid/ready. Select codes above
// the last legal code are flagged as illegal and their result forced to zero.
//
// Reset asserts asynchronously. Deassertion of i_rst_n is expected to be
// synchronous to i_clk, typically via an upstream reset synchroniser.

module alu_cmd_stage #(
  parameter int WIDTH         = 16,
  parameter int SEL_W         = 4,
  parameter int DEPTH         = 4,
  parameter int MAX_LEGAL_SEL = 11
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  // command side
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [WIDTH-1:0]         i_cmd_a,
  input  logic [WIDTH-1:0]         i_cmd_b,
  input  logic [SEL_W-1:0]         i_cmd_sel,
  // ALU side
  output logic [WIDTH-1:0]         o_alu_a,
  output logic [WIDTH-1:0]         o_alu_b,
  output logic [SEL_W-1:0]         o_alu_sel,
  input  logic [WIDTH-1:0]         i_alu_out,
  // result side
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic [WIDTH-1:0]         o_res_data,
  output logic [SEL_W-1:0]         o_res_sel,
  output logic                     o_res_zero,
  output logic                     o_res_illegal,
  // status
  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [SEL_W-1:0] LAST_LEGAL = SEL_W'(MAX_LEGAL_SEL);

  // ---------------------------------------------------------------------------
  // Command FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem_a   [DEPTH];
  logic [WIDTH-1:0] r_mem_b   [DEPTH];
  logic [SEL_W-1:0] r_mem_sel [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // ---------------------------------------------------------------------------
  // Issue stage (S1) and result register
  // ---------------------------------------------------------------------------
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [SEL_W-1:0] r_alu_sel;

  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [SEL_W-1:0] r_res_sel;
  logic             r_res_zero;
  logic             r_res_illegal;

  // ---------------------------------------------------------------------------
  // Handshake / control wires
  // ---------------------------------------------------------------------------
  logic             w_full;
  logic             w_nonempty;
  logic             w_cmd_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_s1_adv;
  logic             w_s1_load;
  logic             w_res_take;
  logic             w_illegal;
  logic [WIDTH-1:0] w_res_data_next;
  logic             w_res_zero_next;

  // Occupancy flags, readiness and the move conditions of every stage.
  always_comb begin
    w_full      = (r_count == FULL_COUNT);
    w_nonempty  = (r_count != '0);
    // Ready comes from the occupancy register only; the reset term just keeps
    // the command side closed for as long as reset is held.
    w_cmd_ready = i_rst_n && !w_full;
    w_push      = i_cmd_valid && w_cmd_ready;
    // S1 hands its operation to the result register whenever that register
    // is empty or is being drained in this same cycle.
    w_s1_adv    = r_s1_valid && (!r_res_valid || i_res_ready);
    // S1 refills from the FIFO head when it is empty or being vacated.
    w_s1_load   = w_nonempty && (!r_s1_valid || w_s1_adv);
    w_pop       = w_s1_load;
    w_res_take  = r_res_valid && i_res_ready;
  end

  // Sanitise the ALU result: undefined select codes produce zero data and
  // never report a zero result.
  always_comb begin
    w_illegal       = (r_alu_sel > LAST_LEGAL);
    w_res_data_next = w_illegal ? '0 : i_alu_out;
    w_res_zero_next = !w_illegal && (i_alu_out == '0);
  end

  // FIFO storage write; entries need no reset since occupancy guards reads.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= i_cmd_a;
      r_mem_b[r_wr_ptr]   <= i_cmd_b;
      r_mem_sel[r_wr_ptr] <= i_cmd_sel;
    end
  end

  // Write pointer advances on every accepted command and wraps modulo DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer advances each time S1 takes the FIFO head.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy counter; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CNT_W'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // S1 valid bit: set on a load, cleared when it advances with nothing behind.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S1 operands feed the ALU and only change on a load, so the ALU inputs
  // stay stable while the result side is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
    end else if (w_s1_load) begin
      r_alu_a   <= r_mem_a[r_rd_ptr];
      r_alu_b   <= r_mem_b[r_rd_ptr];
      r_alu_sel <= r_mem_sel[r_rd_ptr];
    end
  end

  // Result valid: set on capture, cleared only when drained with no refill.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_res_valid <= 1'b1;
    end else if (w_res_take) begin
      r_res_valid <= 1'b0;
    end
  end

  // Result payload captures the ALU output when S1 advances and otherwise
  // holds, keeping data and flags stable until the consumer accepts them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_data    <= '0;
      r_res_sel     <= '0;
      r_res_zero    <= 1'b0;
      r_res_illegal <= 1'b0;
    end else if (w_s1_adv) begin
      r_res_data    <= w_res_data_next;
      r_res_sel     <= r_alu_sel;
      r_res_zero    <= w_res_zero_next;
      r_res_illegal <= w_illegal;
    end
  end

  // Output wiring.
  assign o_cmd_ready   = w_cmd_ready;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_sel     = r_alu_sel;
  assign o_res_valid   = r_res_valid;
  assign o_res_data    = r_res_data;
  assign o_res_sel     = r_res_sel;
  assign o_res_zero    = r_res_zero;
  assign o_res_illegal = r_res_illegal;
  assign o_fifo_count  = r_count;

endmodule

// File: tb/tb_alu_cmd_stage.sv
// Testbench for alu_cmd_stage. A behavioural ALU drives the ALU input, and a
// queue of expected results (computed from each accepted command) checks
// every result the consumer takes, in order.

module tb_alu_cmd_stage;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [3:0]  cmd_sel;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_sel;
  logic        res_zero;
  logic        res_illegal;
  logic [2:0]  fifo_count;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  sel;
    logic        zero;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic        acc;
  logic        tak;
  logic        stall_prev = 1'b0;
  logic [15:0] held_data;
  logic [3:0]  held_sel;
  int          idx;

  alu_cmd_stage dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_a      (cmd_a),
    .i_cmd_b      (cmd_b),
    .i_cmd_sel    (cmd_sel),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_sel    (alu_sel),
    .i_alu_out    (alu_out),
    .o_res_valid  (res_valid),
    .i_res_ready  (res_ready),
    .o_res_data   (res_data),
    .o_res_sel    (res_sel),
    .o_res_zero   (res_zero),
    .o_res_illegal(res_illegal),
    .o_fifo_count (fifo_count)
  );

  // Behavioural stand-in for the 16-bit ALU; undefined codes return junk.
  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] s);
    case (s)
      4'd0:    alu_fn = a + b;
      4'd1:    alu_fn = a - b;
      4'd2:    alu_fn = a * b;
      4'd3:    alu_fn = a & b;
      4'd4:    alu_fn = a | b;
      4'd5:    alu_fn = a ^ b;
      4'd6:    alu_fn = ~a;
      4'd7:    alu_fn = a << b[3:0];
      4'd8:    alu_fn = a >> b[3:0];
      4'd9:    alu_fn = a;
      4'd10:   alu_fn = b;
      4'd11:   alu_fn = {15'd0, (a < b)};
      default: alu_fn = 16'hDEAD;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_a, alu_b, alu_sel);

  // Expected result of one command, straight from the select-code rules.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] s);
    exp_t        e;
    logic [15:0] r;
    r      = alu_fn(a, b, s);
    e.ill  = (s >= 4'd12);
    e.data = e.ill ? 16'h0000 : r;
    e.zero = !e.ill && (r == 16'h0000);
    e.sel  = s;
    return e;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Handshakes decided
  // here take effect at the rising edge in between.
  task automatic step();
    exp_t e;
    #1;
    if (stall_prev) begin
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'(res_data), 32'(held_data));
      check("hold_sel", 32'(res_sel), 32'(held_sel));
    end
    acc = cmd_valid && cmd_ready;
    tak = res_valid && res_ready;
    if (tak) begin
      if (exp_q.size() == 0) begin
        check("res_unexpected", 32'(res_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_sel", 32'(res_sel), 32'(e.sel));
        check("res_zero", 32'(res_zero), 32'(e.zero));
        check("res_illegal", 32'(res_illegal), 32'(e.ill));
      end
    end
    if (acc) exp_q.push_back(model(cmd_a, cmd_b, cmd_sel));
    stall_prev = res_valid && !res_ready;
    held_data  = res_data;
    held_sel   = res_sel;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
    logic done;
    done      = 1'b0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_sel   = s;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = acc;
    end
    cmd_valid = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic drain();
    res_ready = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !res_valid) break;
      step();
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_res_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_sel   = '0;
    res_ready = 1'b0;

    // ---- power-on reset ----
    #2 rst_n = 1'b0;
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready_held", 32'(cmd_ready), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_flags", 32'({res_zero, res_illegal, res_sel}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    $display("[TB] reset checks done");

    // ---- basic latency: accept t0, S1 t1, result t2 ----
    cmd_a = 16'h0003; cmd_b = 16'h0004; cmd_sel = 4'd0;
    cmd_valid = 1'b1; res_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("lat_t0_accept", 32'(acc), 32'd1);
    check("lat_t0_res_valid", 32'(res_valid), 32'd0);
    check("lat_t0_count", 32'(fifo_count), 32'd1);
    step();
    check("lat_t1_alu_a", 32'(alu_a), 32'h3);
    check("lat_t1_alu_b", 32'(alu_b), 32'h4);
    check("lat_t1_res_valid", 32'(res_valid), 32'd0);
    check("lat_t1_count", 32'(fifo_count), 32'd0);
    step();
    check("lat_t2_res_valid", 32'(res_valid), 32'd1);
    check("lat_t2_res_data", 32'(res_data), 32'h7);
    check("lat_t2_res_zero", 32'(res_zero), 32'd0);
    check("lat_t2_res_illegal", 32'(res_illegal), 32'd0);
    drain();
    $display("[TB] basic 3+4 transaction done");

    // ---- wrap / zero results ----
    send(16'hFFFF, 16'h0001, 4'd0);
    send(16'h0100, 16'h0100, 4'd2);
    drain();
    $display("[TB] wrap/zero transactions done");

    // ---- backpressure: 8 commands, consumer stalled ----
    res_ready = 1'b0;
    idx       = 1;
    cmd_b     = 16'hFFFF;
    cmd_sel   = 4'd3;
    cmd_a     = 16'(idx);
    cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (acc) idx++;
      cmd_a     = 16'(idx);
      cmd_valid = (idx <= 8);
    end
    check("bp_accepted", 32'(idx - 1), 32'd6);
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_fifo_count", 32'(fifo_count), 32'd4);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    check("bp_res_data", 32'(res_data), 32'd1);
    check("bp_alu_a", 32'(alu_a), 32'd2);
    res_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check("bp_stream_valid", 32'(res_valid), 32'd1);
      step();
      if (acc) idx++;
      cmd_a     = 16'(idx);
      cmd_valid = (idx <= 8);
    end
    check("bp_all_accepted", 32'(idx - 1), 32'd8);
    drain();
    $display("[TB] backpressure 8-command transaction done");

    // ---- illegal select then legal ----
    send(16'h1234, 16'h0000, 4'd13);
    send(16'h0000, 16'h00AA, 4'd4);
    drain();
    $display("[TB] illegal-select transactions done");

    // ---- concurrent push/pop with FIFO holding 2 ----
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), 4'($urandom_range(0, 11)));
    check("cc_fill_count", 32'(fifo_count), 32'd2);
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cmd_a     = 16'($urandom);
      cmd_b     = 16'($urandom);
      cmd_sel   = 4'($urandom_range(0, 15));
      cmd_valid = 1'b1;
      step();
      check("cc_fifo_count", 32'(fifo_count), 32'd2);
      check("cc_res_valid", 32'(res_valid), 32'd1);
    end
    cmd_valid = 1'b0;
    drain();
    $display("[TB] concurrent push/pop transactions done");

    // ---- randomized traffic ----
    for (int c = 0; c < 300; c++) begin
      cmd_a     = 16'($urandom);
      cmd_b     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      cmd_sel   = 4'($urandom_range(0, 15));
      cmd_valid = ($urandom_range(0, 1) == 1);
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
    $display("[TB] randomized traffic done");

    // ---- reset mid-operation ----
    res_ready = 1'b0;
    send(16'h0011, 16'h0022, 4'd0);
    send(16'h0033, 16'h0044, 4'd1);
    send(16'h0055, 16'h0066, 4'd5);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    stall_prev = 1'b0;
    check("mrst_res_valid", 32'(res_valid), 32'd0);
    check("mrst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mrst_fifo_count", 32'(fifo_count), 32'd0);
    check("mrst_alu", 32'({alu_a, alu_sel}), 32'd0);
    check("mrst_res_data", 32'(res_data), 32'd0);
    check("mrst_res_flags", 32'({res_zero, res_illegal, res_sel}), 32'd0);
    @(negedge clk);
    check("mrst_cmd_ready_held", 32'(cmd_ready), 32'd0);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("mrst_no_stale_result", 32'(res_valid), 32'd0);
      step();
    end
    send(16'h0101, 16'h0202, 4'd0);
    drain();
    $display("[TB] mid-operation reset transaction done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
